i2c_cfg_sequencer: RTL



---
 rtl/i2c_cfg_sequencer_pkg.sv | 24 ++
 rtl/i2c_cfg_rom.sv | 29 ++
 rtl/i2c_cfg_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/i2c_cfg_sequencer_pkg.sv
// Shared definitions for the I2C configuration sequencer: state encoding,
// table geometry and default run parameters.
package i2c_cfg_sequencer_pkg;

    localparam int ADDR_W          = 4;
    localparam int DATA_W          = 24;

    localparam int DEF_NUM_WORDS   = 12;
    localparam int DEF_MAX_RETRY   = 3;
    localparam int DEF_GAP_CYCLES  = 4;
    localparam int DEF_TIMEOUT     = 255;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PREP,
        S_GO,
        S_CHECK,
        S_GAP,
        S_DONE,
        S_FAIL
    } state_t;

endpackage

// File: rtl/i2c_cfg_rom.sv
// Combinational 16x24 configuration table: {slave addr, sub-addr, data}.
module i2c_cfg_rom
    import i2c_cfg_sequencer_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    // NOTE: default assignment first so every path drives data and no latch is inferred.
    always_comb begin
        data = '0;
        case (addr)
            4'd0:    data = 24'h42_12_80;
            4'd1:    data = 24'h42_11_01;
            4'd2:    data = 24'h42_0C_04;
            4'd3:    data = 24'h42_3E_19;
            4'd4:    data = 24'h42_70_3A;
            4'd5:    data = 24'h42_71_35;
            4'd6:    data = 24'h42_72_11;
            4'd7:    data = 24'h42_73_F1;
            4'd8:    data = 24'h42_A2_02;
            4'd9:    data = 24'h42_40_D0;
            4'd10:   data = 24'h42_8C_00;
            4'd11:   data = 24'h42_3A_04;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks the configuration table, handing one word per transfer to the I2C
// programmer, with per-word NACK retry and a GO-phase timeout.
module i2c_cfg_sequencer
    import i2c_cfg_sequencer_pkg::*;
#(
    parameter int NUM_WORDS  = DEF_NUM_WORDS,
    parameter int MAX_RETRY  = DEF_MAX_RETRY,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              i2c_clk,
    input  logic              RESET,
    input  logic              start,
    input  logic              mend,
    input  logic              mack,
    output logic              mgo,
    output logic [DATA_W-1:0] i2c_data,
    output logic [ADDR_W-1:0] mstep,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] fail_index
);

    localparam int CNT_W = 16;
    localparam int RTY_W = 8;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  tcnt;
    logic [RTY_W-1:0]  retry_cnt;
    logic              armed;
    logic              timed_out;
    logic              nack;
    logic              last_word;
    logic              go_end;
    logic              go_expire;
    logic [DATA_W-1:0] rom_data;

    i2c_cfg_rom u_rom (
        .addr (mstep),
        .data (rom_data)
    );

    // A timeout is handled exactly like a NACK from the slave.
    assign nack      = mack | timed_out;
    assign last_word = (mstep == ADDR_W'(NUM_WORDS - 1));
    assign go_end    = armed & mend;
    assign go_expire = (tcnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge i2c_clk or negedge RESET) begin
        if (!RESET) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_FAIL: if (start) state_next = S_LOAD;
            S_LOAD:  state_next = S_PREP;
            S_PREP:  if (cnt == CNT_W'(1)) state_next = S_GO;
            S_GO:    if (go_end || go_expire) state_next = S_CHECK;
            S_CHECK: begin
                if (!nack)                               state_next = last_word ? S_DONE : S_GAP;
                else if (retry_cnt == RTY_W'(MAX_RETRY)) state_next = S_FAIL;
                else                                     state_next = S_GAP;
            end
            S_GAP:   if (cnt == CNT_W'(GAP_CYCLES - 1)) state_next = S_LOAD;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mgo   = (state == S_GO);
        busy  = !(state == S_IDLE || state == S_DONE || state == S_FAIL);
        done  = (state == S_DONE);
        error = (state == S_FAIL);
    end

    // NOTE: all state below is sequential, so only non-blocking assignments are used.
    always_ff @(posedge i2c_clk or negedge RESET) begin
        if (!RESET) begin
            i2c_data   <= '0;
            mstep      <= '0;
            fail_index <= '0;
            cnt        <= '0;
            tcnt       <= '0;
            retry_cnt  <= '0;
            armed      <= 1'b0;
            timed_out  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        mstep     <= '0;
                        retry_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    i2c_data <= rom_data;
                    cnt      <= '0;
                end
                S_PREP: begin
                    cnt       <= cnt + CNT_W'(1);
                    tcnt      <= '0;
                    armed     <= 1'b0;
                    timed_out <= 1'b0;
                end
                S_GO: begin
                    if (!mend) armed <= 1'b1;
                    tcnt      <= tcnt + CNT_W'(1);
                    timed_out <= go_expire & ~go_end;
                end
                S_CHECK: begin
                    cnt <= '0;
                    if (!nack) begin
                        retry_cnt <= '0;
                        if (!last_word) mstep <= mstep + ADDR_W'(1);
                    end else if (retry_cnt != RTY_W'(MAX_RETRY)) begin
                        retry_cnt <= retry_cnt + RTY_W'(1);
                    end else begin
                        fail_index <= mstep;
                    end
                end
                S_GAP:   cnt <= cnt + CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule
